// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache with its block fill sequencer.
// 8 lines of 16 bytes; address = {tag[2:0], index[2:0], word[1:0], byte[1:0]}.
// Hits return the instruction combinationally. A miss stalls the CPU while
// a 128-bit block is fetched from instruction memory, then the lookup replays.
//
// Handshakes: the CPU holds read and address stable while busywait=1 and may
// only consume instruction when read=1 and busywait=0. Towards memory,
// mem_read is a level held until the block is accepted; memory raises
// mem_busywait one cycle after seeing mem_read, and the block on mem_readinst
// is taken on the first later edge where mem_busywait=0.
module instruction_cache_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             read,
   input  logic [9:0]       address,
   output logic [31:0]      instruction,
   output logic             busywait,
   output logic             mem_read,
   output logic [5:0]       mem_address,
   input  logic [127:0]     mem_readinst,
   input  logic             mem_busywait,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   // High from the second MEM_READ cycle on; memory's busy flag is only
   // meaningful once it has had a cycle to react to mem_read.
   logic fill_armed;

   logic [127:0] data_mem [8];
   logic [2:0]   tag_mem  [8];
   logic [7:0]   valid;

   logic [2:0] addr_tag;
   logic [2:0] addr_index;
   logic [1:0] addr_word;
   logic       hit;
   logic       hit_inc;
   logic       miss_inc;
   logic       unused_byte_bits;

   assign addr_tag         = address[9:7];
   assign addr_index       = address[6:4];
   assign addr_word        = address[3:2];
   assign unused_byte_bits = &{1'b0, address[1:0]};
   assign mem_address      = address[9:4];

   assign hit = valid[addr_index] && (tag_mem[addr_index] == addr_tag);

   // Word select from the addressed line; word 0 sits in the low bits.
   always_comb begin
      instruction = 32'h0;
      case (addr_word)
         2'd0:    instruction = data_mem[addr_index][31:0];
         2'd1:    instruction = data_mem[addr_index][63:32];
         2'd2:    instruction = data_mem[addr_index][95:64];
         default: instruction = data_mem[addr_index][127:96];
      endcase
   end

   // State register and fill-arm flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fill_armed <= 1'b0;
      end else begin
         state      <= next_state;
         fill_armed <= (state == MEM_READ);
      end
   end

   // Next state, stall and memory request, counter strobes.
   always_comb begin
      next_state = state;
      mem_read   = 1'b0;
      busywait   = 1'b0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      case (state)
         IDLE: begin
            busywait = read && !hit;
            if (read) begin
               if (hit) begin
                  hit_inc = 1'b1;
               end else begin
                  miss_inc   = 1'b1;
                  next_state = MEM_READ;
               end
            end
         end
         MEM_READ: begin
            mem_read = 1'b1;
            busywait = 1'b1;
            if (fill_armed && !mem_busywait) begin
               next_state = UPDATE;
            end
         end
         UPDATE: begin
            busywait   = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Valid bits are the only reset line state; a fill marks its line valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= 8'h00;
      end else if (state == UPDATE) begin
         valid[addr_index] <= 1'b1;
      end
   end

   // Line data and tag capture; no reset needed as valid gates their use.
   always_ff @(posedge clock) begin
      if (state == UPDATE) begin
         data_mem[addr_index] <= mem_readinst;
         tag_mem[addr_index]  <= addr_tag;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + 1'b1;
         end
         if (miss_inc && (miss_count != {CNT_W{1'b1}})) begin
            miss_count <= miss_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed bench for instruction_cache_controller with a behavioural
// instruction memory. Block b, word w holds {w, b+6, w+2, b+5} (bytes,
// MSB first), so expected instructions below are worked out by hand.
module tb_instruction_cache_controller;

   localparam int CNT_W = 4;

   logic             clock;
   logic             reset;
   logic             read;
   logic [9:0]       address;
   logic [31:0]      instruction;
   logic             busywait;
   logic             mem_read;
   logic [5:0]       mem_address;
   logic [127:0]     mem_readinst;
   logic             mem_busywait;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   int n_checks;
   int n_errors;
   int mem_latency;
   int busy_cnt;

   instruction_cache_controller #(.CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .read         (read),
      .address      (address),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readinst (mem_readinst),
      .mem_busywait (mem_busywait),
      .hit_count    (hit_count),
      .miss_count   (miss_count)
   );

   // Clock: period 10, rising edges at 5, 15, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [127:0] make_block(input logic [5:0] b);
      logic [127:0] d;
      logic [7:0]   bb;
      bb = {2'b00, b};
      for (int w = 0; w < 4; w++) begin
         d[w*32 +: 32] = {8'(w), bb + 8'd6, 8'(w + 2), bb + 8'd5};
      end
      return d;
   endfunction

   // Instruction memory model: raises busy on the negedge after it sees
   // mem_read, stays busy for mem_latency negedges, block held meanwhile.
   always @(negedge clock) begin
      if (reset) begin
         mem_busywait = 1'b0;
         busy_cnt     = 0;
      end else if (mem_read && !mem_busywait && busy_cnt == 0) begin
         mem_busywait = 1'b1;
         busy_cnt     = mem_latency;
         mem_readinst = make_block(mem_address);
      end else if (mem_busywait) begin
         busy_cnt = busy_cnt - 1;
         if (busy_cnt == 0) mem_busywait = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Called at posedge+1. Issues a fetch, waits out any stall (bounded),
   // checks the instruction and stall length, returns at the next posedge+1.
   task automatic fetch(input string tag, input logic [9:0] a, input logic [31:0] exp_instr,
                        input int exp_stall, input int exp_mr_cycles, input int exp_mem_addr);
      int          stall;
      int          mr_cycles;
      logic [31:0] seen_addr;
      read      = 1'b1;
      address   = a;
      stall     = 0;
      mr_cycles = 0;
      seen_addr = 32'hFFFF_FFFF;
      @(negedge clock); #1;
      while (busywait && stall < 200) begin
         stall++;
         if (mem_read) begin
            mr_cycles++;
            seen_addr = {26'd0, mem_address};
         end
         @(negedge clock); #1;
      end
      check({tag, "_instr"}, instruction, exp_instr);
      check({tag, "_stall"}, stall, exp_stall);
      if (exp_stall > 0) begin
         check({tag, "_mr_cycles"}, mr_cycles, exp_mr_cycles);
         check({tag, "_mem_addr"}, seen_addr, exp_mem_addr);
      end
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      read  = 1'b0;
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      mem_latency  = 1;
      busy_cnt     = 0;
      mem_busywait = 1'b0;
      mem_readinst = '0;
      reset        = 1'b1;
      read         = 1'b0;
      address      = 10'h3F0;

      // Reset state.
      #2;
      check("rst_busywait", busywait, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_hits", hit_count, 0);
      check("rst_misses", miss_count, 0);
      check("rst_mem_address", mem_address, 6'h3F);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      // Cold miss then hit: 1 + 2 + 1 stall cycles.
      fetch("cold", 10'h008, 32'h02060405, 4, 2, 0);
      check("cold_misses", miss_count, 1);
      check("cold_hits", hit_count, 1);

      // Same-line hits on consecutive cycles.
      fetch("hit0", 10'h000, 32'h00060205, 0, 0, 0);
      fetch("hit1", 10'h004, 32'h01060305, 0, 0, 0);
      fetch("hit3", 10'h00C, 32'h03060505, 0, 0, 0);
      check("seq_hits", hit_count, 4);
      read = 1'b0;
      @(posedge clock); #1;
      check("idle_no_count", hit_count, 4);

      // Conflict replacement on index 1.
      do_reset();
      fetch("conf_a", 10'h010, 32'h00070206, 4, 2, 1);
      fetch("conf_b", 10'h090, 32'h000F020E, 4, 2, 9);
      fetch("conf_c", 10'h010, 32'h00070206, 4, 2, 1);
      check("conf_misses", miss_count, 3);
      check("conf_hits", hit_count, 3);

      // Slow memory: 10 busy cycles gives 11 MEM_READ cycles.
      mem_latency = 10;
      fetch("slow", 10'h0F4, 32'h01150314, 13, 11, 6'h0F);
      check("slow_misses", miss_count, 4);

      // Reset mid-fill.
      @(negedge clock); #1;
      read    = 1'b1;
      address = 10'h1A8;
      @(negedge clock); #1;
      @(negedge clock); #1;
      @(negedge clock); #1;
      check("midfill_mem_read", mem_read, 1);
      reset = 1'b1;
      read  = 1'b0;
      #1;
      check("midfill_rst_mem_read", mem_read, 0);
      check("midfill_rst_busywait", busywait, 0);
      check("midfill_rst_hits", hit_count, 0);
      check("midfill_rst_misses", miss_count, 0);
      @(negedge clock);
      @(posedge clock); #1;
      reset       = 1'b0;
      mem_latency = 1;
      fetch("refill", 10'h1A8, 32'h0220041F, 4, 2, 6'h1A);
      check("refill_misses", miss_count, 1);
      check("refill_hits", hit_count, 1);

      // Counter saturation at 15 with CNT_W=4.
      for (int i = 0; i < 14; i++) begin
         fetch("sat_hit", 10'h1A8, 32'h0220041F, 0, 0, 0);
      end
      check("sat_at_max", hit_count, 15);
      for (int i = 0; i < 6; i++) begin
         fetch("sat_hold", 10'h1A8, 32'h0220041F, 0, 0, 0);
      end
      check("sat_no_wrap", hit_count, 15);
      check("sat_misses", miss_count, 1);
      read = 1'b0;
      @(posedge clock); #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
